// File: rtl/frame_unloader.sv
// Frame unloader: emits a 4-byte header (preamble, size LE) followed by each
// 32-bit frame word little-endian on a byte stream, one frame per frame_ready edge.
module frame_unloader #(
   parameter logic [15:0] PREAMBLE = 16'hA55A
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_frame_ready,
   input  logic [15:0] i_frame_size,
   input  logic [31:0] i_in_data,
   input  logic        i_in_vld,
   output logic        o_in_rdy,
   output logic [7:0]  o_byte,
   output logic        o_byte_vld,
   input  logic        i_byte_rdy,
   input  logic        i_clr_ovr,
   output logic        o_busy,
   output logic        o_frame_done,
   output logic        o_overrun,
   output logic [15:0] o_frame_count
);

   // state | meaning
   // IDLE  | waiting for a frame_ready rising edge
   // PRE   | emitting preamble high/low, size low/high
   // LOAD  | accepting the next frame word
   // SEND  | emitting the captured word, byte 0 first
   // DONE  | frame_done pulse, frame count already bumped
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PRE  = 3'd1,
      S_LOAD = 3'd2,
      S_SEND = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic        rdy_q, rdy_d;
   logic [15:0] size_q, size_d;
   logic [15:0] cnt_q, cnt_d;
   logic [31:0] word_q, word_d;
   logic [1:0]  idx_q, idx_d;
   logic [7:0]  byte_q, byte_d;
   logic        byte_vld_q, byte_vld_d;
   logic        done_q, done_d;
   logic        ovr_q, ovr_d;
   logic [15:0] count_q, count_d;

   logic start;
   logic accept;

   assign start  = i_frame_ready & ~rdy_q;
   assign accept = byte_vld_q & i_byte_rdy;

   always_comb begin
      state_d    = state_q;
      rdy_d      = i_frame_ready;
      size_d     = size_q;
      cnt_d      = cnt_q;
      word_d     = word_q;
      idx_d      = idx_q;
      byte_d     = byte_q;
      byte_vld_d = byte_vld_q;
      done_d     = 1'b0;
      ovr_d      = ovr_q;
      count_d    = count_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               size_d     = i_frame_size;
               cnt_d      = i_frame_size;
               byte_d     = PREAMBLE[15:8];
               byte_vld_d = 1'b1;
               idx_d      = 2'd0;
               state_d    = S_PRE;
            end
         end
         S_PRE: begin
            if (accept) begin
               idx_d = idx_q + 2'd1;
               case (idx_q)
                  2'd0: byte_d = PREAMBLE[7:0];
                  2'd1: byte_d = size_q[7:0];
                  2'd2: byte_d = size_q[15:8];
                  default: begin
                     byte_vld_d = 1'b0;
                     if (size_q == 16'd0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        count_d = count_q + 16'd1;
                     end else begin
                        state_d = S_LOAD;
                     end
                  end
               endcase
            end
         end
         S_LOAD: begin
            if (i_in_vld) begin
               word_d     = i_in_data;
               cnt_d      = cnt_q - 16'd1;
               byte_d     = i_in_data[7:0];
               byte_vld_d = 1'b1;
               idx_d      = 2'd0;
               state_d    = S_SEND;
            end
         end
         S_SEND: begin
            if (accept) begin
               idx_d = idx_q + 2'd1;
               case (idx_q)
                  2'd0: byte_d = word_q[15:8];
                  2'd1: byte_d = word_q[23:16];
                  2'd2: byte_d = word_q[31:24];
                  default: begin
                     byte_vld_d = 1'b0;
                     if (cnt_q != 16'd0) begin
                        state_d = S_LOAD;
                     end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        count_d = count_q + 16'd1;
                     end
                  end
               endcase
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // a set in the same cycle as a clear must win
      if (start && (state_q != S_IDLE)) begin
         ovr_d = 1'b1;
      end else if (i_clr_ovr) begin
         ovr_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         rdy_q      <= 1'b0;
         size_q     <= 16'd0;
         cnt_q      <= 16'd0;
         word_q     <= 32'd0;
         idx_q      <= 2'd0;
         byte_q     <= 8'd0;
         byte_vld_q <= 1'b0;
         done_q     <= 1'b0;
         ovr_q      <= 1'b0;
         count_q    <= 16'd0;
      end else begin
         state_q    <= state_d;
         rdy_q      <= rdy_d;
         size_q     <= size_d;
         cnt_q      <= cnt_d;
         word_q     <= word_d;
         idx_q      <= idx_d;
         byte_q     <= byte_d;
         byte_vld_q <= byte_vld_d;
         done_q     <= done_d;
         ovr_q      <= ovr_d;
         count_q    <= count_d;
      end
   end

   assign o_in_rdy      = (state_q == S_LOAD);
   assign o_busy        = (state_q != S_IDLE);
   assign o_byte        = byte_q;
   assign o_byte_vld    = byte_vld_q;
   assign o_frame_done  = done_q;
   assign o_overrun     = ovr_q;
   assign o_frame_count = count_q;

endmodule

// File: tb/tb_frame_unloader.sv
// Scoreboard bench for frame_unloader: expected bytes are queued when a frame
// is issued and popped by a monitor on every byte handshake.
module tb_frame_unloader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_frame_ready = 1'b0;
   logic [15:0] i_frame_size = 16'd0;
   logic [31:0] i_in_data = 32'd0;
   logic        i_in_vld = 1'b0;
   logic        o_in_rdy;
   logic [7:0]  o_byte;
   logic        o_byte_vld;
   logic        i_byte_rdy = 1'b1;
   logic        i_clr_ovr = 1'b0;
   logic        o_busy;
   logic        o_frame_done;
   logic        o_overrun;
   logic [15:0] o_frame_count;

   frame_unloader #(.PREAMBLE(16'hA55A)) dut (
      .clk(clk), .rst(rst), .i_frame_ready(i_frame_ready), .i_frame_size(i_frame_size),
      .i_in_data(i_in_data), .i_in_vld(i_in_vld), .o_in_rdy(o_in_rdy),
      .o_byte(o_byte), .o_byte_vld(o_byte_vld), .i_byte_rdy(i_byte_rdy),
      .i_clr_ovr(i_clr_ovr), .o_busy(o_busy), .o_frame_done(o_frame_done),
      .o_overrun(o_overrun), .o_frame_count(o_frame_count)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [7:0]  exp_q[$];
   logic [31:0] wq[$];
   bit          gap_mode = 1'b0;
   bit          in_go = 1'b0;
   bit          prev_stall = 1'b0;
   logic [7:0]  prev_byte = 8'd0;
   int          done_cnt = 0;
   bit          in_rdy_seen = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: sample mid-cycle, handshake completes at the following rising edge
   always @(negedge clk) begin
      in_go = i_in_vld && o_in_rdy;
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_vld", {31'd0, o_byte_vld}, 32'd1);
            chk("stall_byte", {24'd0, o_byte}, {24'd0, prev_byte});
         end
         if (o_byte_vld && i_byte_rdy) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_byte", {24'd0, o_byte}, 32'hFFFF_FFFF);
            end else begin
               chk("byte", {24'd0, o_byte}, {24'd0, exp_q.pop_front()});
            end
         end
         prev_stall = o_byte_vld && !i_byte_rdy;
         prev_byte  = o_byte;
         if (o_frame_done) done_cnt++;
         if (o_in_rdy) in_rdy_seen = 1'b1;
      end
   end

   // word source and host-ready driver
   always @(posedge clk) begin
      #1;
      if (in_go && wq.size() > 0) void'(wq.pop_front());
      if (wq.size() > 0 && (!gap_mode || $urandom_range(0, 2) != 0)) begin
         i_in_vld  = 1'b1;
         i_in_data = wq[0];
      end else begin
         i_in_vld  = 1'b0;
      end
      i_byte_rdy = gap_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_frame(input logic [15:0] sz, input logic [31:0] w[$]);
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h5A);
      exp_q.push_back(sz[7:0]);
      exp_q.push_back(sz[15:8]);
      foreach (w[k]) begin
         exp_q.push_back(w[k][7:0]);
         exp_q.push_back(w[k][15:8]);
         exp_q.push_back(w[k][23:16]);
         exp_q.push_back(w[k][31:24]);
         wq.push_back(w[k]);
      end
   endtask

   task automatic start_frame(input logic [15:0] sz, input logic [31:0] w[$]);
      push_frame(sz, w);
      i_frame_size  = sz;
      i_frame_ready = 1'b1;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int c;
      for (c = 0; c < budget; c++) begin
         cyc(1);
         if (exp_q.size() == 0 && !o_busy) break;
      end
      chk({name, "_timeout"}, {31'd0, (c >= budget)}, 32'd0);
   endtask

   task automatic wait_left(input int left, input int budget);
      int c;
      for (c = 0; c < budget; c++) begin
         cyc(1);
         if (exp_q.size() <= left) break;
      end
      chk("wait_left_timeout", {31'd0, (c >= budget)}, 32'd0);
   endtask

   initial begin
      logic [31:0] w[$];
      int d0;

      cyc(3);
      chk("rst_byte_vld", {31'd0, o_byte_vld}, 32'd0);
      chk("rst_byte", {24'd0, o_byte}, 32'd0);
      chk("rst_in_rdy", {31'd0, o_in_rdy}, 32'd0);
      chk("rst_busy", {31'd0, o_busy}, 32'd0);
      chk("rst_done", {31'd0, o_frame_done}, 32'd0);
      chk("rst_ovr", {31'd0, o_overrun}, 32'd0);
      chk("rst_count", {16'd0, o_frame_count}, 32'd0);
      rst = 1'b0;
      cyc(2);

      // two-word frame, frame_ready left high afterwards
      w = '{32'h11223344, 32'hAABBCCDD};
      start_frame(16'd2, w);
      wait_idle("f2", 200);
      chk("f2_done", done_cnt, 1);
      chk("f2_count", {16'd0, o_frame_count}, 32'd1);
      cyc(20);
      chk("held_ready_busy", {31'd0, o_busy}, 32'd0);
      chk("held_ready_count", {16'd0, o_frame_count}, 32'd1);
      chk("held_ready_ovr", {31'd0, o_overrun}, 32'd0);
      i_frame_ready = 1'b0;
      cyc(2);

      // empty frame: header only
      in_rdy_seen = 1'b0;
      w = {};
      start_frame(16'd0, w);
      cyc(2);
      i_frame_ready = 1'b0;
      wait_idle("f0", 100);
      chk("f0_in_rdy_seen", {31'd0, in_rdy_seen}, 32'd0);
      chk("f0_done", done_cnt, 2);
      chk("f0_count", {16'd0, o_frame_count}, 32'd2);

      // gapped handshakes on both sides
      gap_mode = 1'b1;
      w = '{32'h01020304, 32'hDEADBEEF, 32'hCAFEF00D};
      start_frame(16'd3, w);
      cyc(2);
      i_frame_ready = 1'b0;
      wait_idle("f3", 1000);
      gap_mode = 1'b0;
      chk("f3_done", done_cnt, 3);
      chk("f3_count", {16'd0, o_frame_count}, 32'd3);

      // second edge during SEND
      w = '{32'h55667788, 32'h99AABBCC};
      start_frame(16'd2, w);
      cyc(2);
      i_frame_ready = 1'b0;
      wait_left(7, 100);
      chk("ovr_pre_edge", {31'd0, o_overrun}, 32'd0);
      i_frame_ready = 1'b1;
      cyc(1);
      i_frame_ready = 1'b0;
      chk("ovr_set", {31'd0, o_overrun}, 32'd1);
      wait_idle("fovr", 200);
      chk("fovr_done", done_cnt, 4);
      chk("fovr_count", {16'd0, o_frame_count}, 32'd4);
      chk("ovr_sticky", {31'd0, o_overrun}, 32'd1);
      i_clr_ovr = 1'b1;
      cyc(1);
      i_clr_ovr = 1'b0;
      chk("ovr_clr", {31'd0, o_overrun}, 32'd0);

      // clear and overrun in the same cycle
      w = {};
      start_frame(16'd0, w);
      cyc(1);
      i_frame_ready = 1'b0;
      cyc(1);
      i_frame_ready = 1'b1;
      i_clr_ovr     = 1'b1;
      cyc(1);
      i_clr_ovr     = 1'b0;
      i_frame_ready = 1'b0;
      chk("ovr_set_wins", {31'd0, o_overrun}, 32'd1);
      wait_idle("fsw", 100);
      chk("fsw_count", {16'd0, o_frame_count}, 32'd5);
      i_clr_ovr = 1'b1;
      cyc(1);
      i_clr_ovr = 1'b0;

      // reset mid-frame, frame_ready already high at release
      w = '{32'h10203040, 32'h50607080, 32'h90A0B0C0, 32'hD0E0F000};
      start_frame(16'd4, w);
      cyc(2);
      i_frame_ready = 1'b0;
      wait_left(15, 100);
      d0 = done_cnt;
      rst = 1'b1;
      #1;
      chk("mid_rst_byte_vld", {31'd0, o_byte_vld}, 32'd0);
      chk("mid_rst_byte", {24'd0, o_byte}, 32'd0);
      chk("mid_rst_busy", {31'd0, o_busy}, 32'd0);
      chk("mid_rst_in_rdy", {31'd0, o_in_rdy}, 32'd0);
      chk("mid_rst_count", {16'd0, o_frame_count}, 32'd0);
      exp_q.delete();
      wq.delete();
      w = '{32'hFEEDC0DE};
      start_frame(16'd1, w);
      cyc(2);
      chk("rst_hold_done", {31'd0, o_frame_done}, 32'd0);
      rst = 1'b0;
      wait_idle("frst", 200);
      i_frame_ready = 1'b0;
      chk("frst_done", done_cnt, d0 + 1);
      chk("frst_count", {16'd0, o_frame_count}, 32'd1);

      // frame counter wrap: preload near the top instead of running 65534 frames
      cyc(1);
      force dut.count_q = 16'hFFFE;
      cyc(1);
      release dut.count_q;
      cyc(1);
      w = {};
      start_frame(16'd0, w);
      cyc(2);
      i_frame_ready = 1'b0;
      wait_idle("fw1", 100);
      chk("wrap_ffff", {16'd0, o_frame_count}, 32'h0000_FFFF);
      start_frame(16'd0, w);
      cyc(2);
      i_frame_ready = 1'b0;
      wait_idle("fw2", 100);
      chk("wrap_zero", {16'd0, o_frame_count}, 32'd0);
      chk("final_exp_empty", exp_q.size(), 0);

      cyc(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
